// File: rtl/memory_pkg.sv
// Shared types, constants and the lane-merge helper for the byte-enable dual-port memory.
package memory_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers cast to and from their own width.
  localparam int MAX_DW = 1024;
  localparam int MAX_BE = MAX_DW / 8;

  typedef enum logic {
    INIT,
    READY
  } state_e;

  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_BE-1:0] be
  );
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_BE; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/memory_dp_be_if.sv
// Write/read port bundle of the byte-enable dual-port memory.
interface memory_dp_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic                  we;
  logic [BE_W-1:0]       wbe;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  re;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  init_busy;

  modport master (
    output we, wbe, waddr, wdata, re, raddr,
    input  rdata, rvalid, init_busy
  );

  modport slave (
    input  we, wbe, waddr, wdata, re, raddr,
    output rdata, rvalid, init_busy
  );

endinterface

// File: rtl/memory_init_seq.sv
// Post-reset zero-fill sequencer: sweeps every address once, then hands the write port back.
// Latency: DEPTH cycles after reset release; nothing can stall the sweep.
module memory_init_seq
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy_o,
  output logic                  init_we_o,
  output logic [ADDR_WIDTH-1:0] init_addr_o
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_ON_RESET != 0) ? INIT : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_we_o = 1'b0;
    case (state_q)
      INIT: begin
        init_we_o = 1'b1;
        cnt_d     = cnt_q + ADDR_WIDTH'(1);
        if (&cnt_q) begin
          state_d = READY;
        end
      end
      default: begin
        state_d = READY;
      end
    endcase
  end

  // Busy is forced during reset so the memory never looks ready before the sweep starts.
  assign init_busy_o = (state_q == INIT) || (rst && (INIT_ON_RESET != 0));
  assign init_addr_o = cnt_q;

endmodule

// File: rtl/memory_dp_be.sv
// Simple-dual-port RAM with byte-enable writes and a 1- or 2-stage registered read.
// Latency: RD_LATENCY cycles re->rvalid; no backpressure, accesses are dropped while init_busy.
module memory_dp_be
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int RD_LATENCY    = 1,
  parameter int RDW_MODE      = RDW_READ_FIRST,
  parameter int INIT_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           rst,
  memory_dp_be_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BE_W  = DATA_WIDTH / 8;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_dw
    $error("memory_dp_be: DATA_WIDTH must be a multiple of 8 and at most MAX_DW");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
    $error("memory_dp_be: RD_LATENCY must be 1 or 2");
  end

  logic                  init_busy;
  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;

  memory_init_seq #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .INIT_ON_RESET (INIT_ON_RESET)
  ) u_init_seq (
    .clk         (clk),
    .rst         (rst),
    .init_busy_o (init_busy),
    .init_we_o   (init_we),
    .init_addr_o (init_addr)
  );

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  access_ok;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic [BE_W-1:0]       wr_be;
  logic [DATA_WIDTH-1:0] wr_word;

  assign access_ok = !rst && !init_busy;

  // The sweep owns the write port while busy; user writes are simply discarded then.
  always_comb begin
    wr_en   = (init_we && !rst) || (access_ok && bus.we);
    wr_addr = bus.waddr;
    wr_dat  = bus.wdata;
    wr_be   = bus.wbe;
    if (init_busy) begin
      wr_addr = init_addr;
      wr_dat  = '0;
      wr_be   = '1;
    end
    wr_word = DATA_WIDTH'(byte_merge(MAX_DW'(mem[wr_addr]), MAX_DW'(wr_dat), MAX_BE'(wr_be)));
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  logic                  rd_fire;
  logic                  collide;
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  s1_vld_q, s1_vld_d;
  logic [DATA_WIDTH-1:0] s1_dat_q, s1_dat_d;

  // Write-first forwards the merged word; read-first relies on the array still holding old data.
  always_comb begin
    rd_fire = access_ok && bus.re;
    collide = rd_fire && bus.we && (bus.waddr == bus.raddr);
    rd_old  = mem[bus.raddr];
    rd_word = rd_old;
    if (RDW_MODE == RDW_WRITE_FIRST && collide) begin
      rd_word = DATA_WIDTH'(byte_merge(MAX_DW'(rd_old), MAX_DW'(bus.wdata), MAX_BE'(bus.wbe)));
    end
    s1_vld_d = rd_fire;
    s1_dat_d = rd_fire ? rd_word : s1_dat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_dat_q <= s1_dat_d;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s2_vld_q;
    logic [DATA_WIDTH-1:0] s2_dat_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_vld_q <= 1'b0;
        s2_dat_q <= '0;
      end else begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          s2_dat_q <= s1_dat_q;
        end
      end
    end

    assign bus.rvalid = s2_vld_q;
    assign bus.rdata  = s2_dat_q;
  end else begin : g_lat1
    assign bus.rvalid = s1_vld_q;
    assign bus.rdata  = s1_dat_q;
  end

  assign bus.init_busy = init_busy;

endmodule
